// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request arbiter.
package cordic_pkg;

    localparam int DEFAULT_DATA_W = 16;

    localparam int SEL_SIN  = 0;
    localparam int SEL_COS  = 1;
    localparam int SEL_TAN  = 2;
    localparam int SEL_ATAN = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } cordic_state_t;

    function automatic logic sel_is_onehot(input logic [3:0] sel);
        return (sel == 4'(1 << SEL_SIN))  || (sel == 4'(1 << SEL_COS)) ||
               (sel == 4'(1 << SEL_TAN))  || (sel == 4'(1 << SEL_ATAN));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its last-granted pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_id,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_id;

    // Reset value 1 makes requester 0 the winner of the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= 1'b1;
        end else if (update) begin
            last_id <= upd_id;
        end
    end

    always_comb begin
        grant_id = 1'b0;
        grant    = '0;
        if (req == 2'b11) begin
            grant_id = ~last_id;
        end else begin
            grant_id = req[1];
        end
        if (req != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/cordic_arb.sv
// Arbitrates two requesters onto one shared fixed-latency CORDIC core.
// Optional CORDIC_ARB_SELCHK_EN: non-one-hot selects bypass the core with res_err=1.
module cordic_arb
    import cordic_pkg::*;
#(
    parameter int LATENCY = 6,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][DATA_W-1:0] req_angle,
    input  logic [1:0][DATA_W-1:0] req_another,
    input  logic [1:0][3:0]        req_select,
    output logic                   core_start,
    output logic [DATA_W-1:0]      core_angle,
    output logic [DATA_W-1:0]      core_another,
    output logic [3:0]             core_select,
    input  logic [DATA_W-1:0]      core_out,
    output logic                   res_valid,
    output logic                   res_id,
    output logic [DATA_W-1:0]      res_data,
    output logic                   res_err,
    input  logic                   res_ready
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    cordic_state_t    state;
    cordic_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             grant_id;
    logic             accept;
    logic             done_xfer;
    logic             sel_bad;

    assign accept    = (state == IDLE) && (req_valid != 2'b00);
    assign done_xfer = (state == DONE) && res_ready;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .update   (done_xfer),
        .upd_id   (res_id),
        .grant    (grant),
        .grant_id (grant_id)
    );

`ifdef CORDIC_ARB_SELCHK_EN
    logic err_q;

    assign sel_bad = !sel_is_onehot(req_select[grant_id]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= sel_bad;
        end
    end

    assign res_err = err_q;
`else
    assign sel_bad = 1'b0;
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_valid != 2'b00) state_nxt = sel_bad ? DONE : ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst also gates the ready path so every output reads 0 while reset is held.
    assign req_ready  = (state == IDLE && !rst) ? grant : 2'b00;
    assign core_start = (state == ISSUE);
    assign res_valid  = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            core_angle   <= '0;
            core_another <= '0;
            core_select  <= '0;
            res_id       <= 1'b0;
            res_data     <= '0;
        end else begin
            if (accept) begin
                core_angle   <= req_angle[grant_id];
                core_another <= req_another[grant_id];
                core_select  <= req_select[grant_id];
                res_id       <= grant_id;
                if (sel_bad) begin
                    res_data <= '0;
                end
            end
            if (state == WAIT) begin
                if (cnt == CNT_LAST) begin
                    cnt      <= '0;
                    res_data <= core_out;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/cordic_arb.md
CORDIC_ARB -- requirements
Module: cordic_arb

Interface
REQ-001 SHALL have parameter LATENCY, default 6: clock cycles from core_start to a valid core_out.
REQ-002 SHALL have parameter DATA_W, default 16: operand and result width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid / req_ready, input / output, 2 bits each: per-requester handshake (bit i = requester i).
REQ-006 SHALL have ports req_angle, req_another, input, 2xDATA_W each: per-requester operands.
REQ-007 SHALL have port req_select, input, 2x4 bits: per-requester function select (bit0 sin, bit1 cos, bit2 tan, bit3 arctan).
REQ-008 SHALL have ports core_start, core_angle, core_another, core_select, outputs, 1 / DATA_W / DATA_W / 4 bits: drive the shared CORDIC core.
REQ-009 SHALL have port core_out, input, DATA_W: result from the core.
REQ-010 SHALL have ports res_valid, res_id, res_data, res_err, outputs, 1 / 1 / DATA_W / 1 bits, and res_ready, input, 1 bit: result handshake.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-012 IDLE: with any req_valid set, SHALL grant one requester by round-robin, pulse that requester's req_ready for one cycle, latch its operands and id, then go to ISSUE.
REQ-013 Round-robin: the requester not granted last SHALL win when both are valid; after reset requester 0 SHALL win.
REQ-014 req_ready SHALL be asserted only in IDLE, and only for the granted requester.
REQ-015 ISSUE: core_start SHALL be 1 for exactly one cycle; SHALL then go to WAIT.
REQ-016 core_angle, core_another and core_select SHALL hold the latched operands from ISSUE until leaving WAIT.
REQ-017 WAIT: a counter SHALL run 0..LATENCY-1; at LATENCY-1 the FSM SHALL capture core_out into res_data and go to DONE.
REQ-018 DONE: res_valid SHALL be 1, with res_id = the granted requester; res_data, res_id and res_err SHALL be stable until the handshake.
REQ-019 DONE: when res_valid && res_ready, the FSM SHALL return to IDLE and update the last-granted pointer.
REQ-020 Total latency from req accept to res_valid SHALL be LATENCY+2 cycles: 1 cycle ISSUE, LATENCY cycles WAIT, then DONE.
REQ-021 Requests arriving outside IDLE SHALL see req_ready=0; the requester holds valid until accepted, and no request is dropped.
REQ-022 If res_ready=0, DONE SHALL persist indefinitely with no new grant.

Reset
REQ-023 On rst: state SHALL be IDLE, pointer SHALL favour requester 0, the counter SHALL be 0, and all outputs SHALL be 0.
REQ-024 rst asserted mid-operation SHALL abort the transaction; no res_valid SHALL follow.

Configuration
REQ-025 With CORDIC_ARB_SELCHK_EN defined, a req_select that is not one-hot SHALL still be accepted, but ISSUE/WAIT SHALL be skipped and the FSM SHALL go directly to DONE with res_err=1 and res_data=0.
REQ-026 Without CORDIC_ARB_SELCHK_EN, res_err SHALL be tied 0 and any select value SHALL be passed to the core unchanged.

Structure
REQ-027 A shared package cordic_pkg SHALL hold the FSM state enum, the select-bit constants (SEL_SIN=0, SEL_COS=1, SEL_TAN=2, SEL_ATAN=3) and the default DATA_W.
REQ-028 The round-robin grant logic SHALL be one sub-module, rr_arb2; all other logic SHALL be flat.

Verification (core replaced by a model: fixed delay LATENCY, core_out = angle + another)
REQ-029 Single request: req0 angle=30, another=0, select=0001 -> req_ready[0] pulses once, core_start pulses once, res_valid on cycle 8 (LATENCY=6), res_id=0, res_data=30.
REQ-030 Contention: both valid from reset -> order of res_id is 0,1,0,1 over four transactions.
REQ-031 Backpressure: res_ready held low 10 cycles -> res_valid and res_data stable, req_ready stays 0, then exactly one transfer.
REQ-032 Reset in WAIT (counter=3) -> all outputs 0 next edge; no res_valid; the next request completes normally.
REQ-033 With CORDIC_ARB_SELCHK_EN, select=0011 -> core_start never asserts, res_err=1, res_data=0; without the macro, core_select=0011 and res_err=0.
REQ-034 LATENCY=1 build: single request -> res_valid 3 cycles after accept.
